// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, port indices
// and write-enable encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_D = 1'b0,
    PORT_I = 1'b1
  } port_t;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_BYTE = 2'b01;
  localparam logic [1:0] WE_HALF = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

  function automatic logic is_write(input logic [1:0] we);
    return we != WE_NONE;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the data and instruction ports.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise data wins ties.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic  d_req,
  input  logic  i_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  port_t last,
`endif
  output port_t win
);

  always_comb begin
    win = PORT_D;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req && !d_req) begin
      win = PORT_I;
    end else if (i_req && d_req && (last == PORT_D)) begin
      win = PORT_I;
    end
`else
    if (i_req && !d_req) begin
      win = PORT_I;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration (default: data priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            d_req,
  input  logic [AW-1:0]   d_addr,
  input  logic [1:0]      d_we,
  input  logic [XLEN-1:0] d_wd,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            d_ack,
  output logic            i_ack,
  output logic [XLEN-1:0] rdata,
  output logic            busy,
  output logic            mem_en,
  output logic [1:0]      mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  port_t             r_gnt;
  port_t             w_win;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [XLEN-1:0]   r_rdata;
  logic [AW-1:0]     r_addr;
  logic [XLEN-1:0]   r_wd;
  logic [1:0]        r_we;
  logic              w_grant;
  logic              w_capture;

`ifdef ARB_ROUND_ROBIN_EN
  port_t             r_last;
`endif

  arb_pick u_pick (
    .d_req (d_req),
    .i_req (i_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last  (r_last),
`endif
    .win   (w_win)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (d_req || i_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (is_write(r_we)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt   = CNT_W'(MEM_LAT - 1);
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Payload is latched on grant rather than muxed in ISSUE: requesters hold it
  // stable, so ISSUE sees the same values with no req-to-mem combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= PORT_D;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_we    <= WE_NONE;
`ifdef ARB_ROUND_ROBIN_EN
      r_last  <= PORT_I;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant) begin
        r_gnt <= w_win;
`ifdef ARB_ROUND_ROBIN_EN
        r_last <= w_win;
`endif
        if (w_win == PORT_D) begin
          r_addr <= d_addr;
          r_wd   <= d_wd;
          r_we   <= d_we;
        end else begin
          r_addr <= i_addr;
          r_we   <= WE_NONE;
        end
      end
      if (w_capture) begin
        r_rdata <= mem_rd;
      end
    end
  end

  assign mem_en   = (r_state == ST_ISSUE);
  assign mem_we   = mem_en ? r_we : WE_NONE;
  assign mem_addr = r_addr;
  assign mem_wd   = r_wd;
  assign busy     = (r_state != ST_IDLE);
  assign d_ack    = (r_state == ST_DONE) && (r_gnt == PORT_D);
  assign i_ack    = (r_state == ST_DONE) && (r_gnt == PORT_I);
  assign rdata    = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: MEM_LAT=1 and MEM_LAT=3 instances,
// each with a behavioural memory; tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        d_req1 = 1'b0, i_req1 = 1'b0;
  logic [31:0] d_addr1 = '0, i_addr1 = '0, d_wd1 = '0;
  logic [1:0]  d_we1 = 2'b00;
  logic        d_ack1, i_ack1, busy1, mem_en1;
  logic [31:0] rdata1, mem_addr1, mem_wd1, mem_rd1;
  logic [1:0]  mem_we1;

  logic        d_req3 = 1'b0, i_req3 = 1'b0;
  logic [31:0] d_addr3 = '0, i_addr3 = '0, d_wd3 = '0;
  logic [1:0]  d_we3 = 2'b00;
  logic        d_ack3, i_ack3, busy3, mem_en3;
  logic [31:0] rdata3, mem_addr3, mem_wd3, mem_rd3;
  logic [1:0]  mem_we3;

  mem_arbiter #(.XLEN(32), .AW(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .d_req(d_req1), .d_addr(d_addr1), .d_we(d_we1), .d_wd(d_wd1),
    .i_req(i_req1), .i_addr(i_addr1),
    .d_ack(d_ack1), .i_ack(i_ack1), .rdata(rdata1), .busy(busy1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wd(mem_wd1), .mem_rd(mem_rd1)
  );

  mem_arbiter #(.XLEN(32), .AW(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .d_req(d_req3), .d_addr(d_addr3), .d_we(d_we3), .d_wd(d_wd3),
    .i_req(i_req3), .i_addr(i_addr3),
    .d_ack(d_ack3), .i_ack(i_ack3), .rdata(rdata3), .busy(busy3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wd(mem_wd3), .mem_rd(mem_rd3)
  );

  // Behavioural memories; read data appears MEM_LAT cycles after the strobe
  // and is poisoned in every other cycle so a mistimed capture is visible.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [0:2];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] we, input logic [1:0] a);
    logic [3:0]  be;
    logic [31:0] r;
    r = old;
    case (we)
      2'b01:   be = 4'b0001 << a;
      2'b10:   be = a[1] ? 4'b1100 : 4'b0011;
      2'b11:   be = 4'hF;
      default: be = 4'h0;
    endcase
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    pipe1 <= (mem_en1 && mem_we1 == 2'b00) ? mem1[mem_addr1[9:2]] : 32'hBAD0_0001;
    if (mem_en1 && mem_we1 != 2'b00)
      mem1[mem_addr1[9:2]] = merge(mem1[mem_addr1[9:2]], mem_wd1, mem_we1, mem_addr1[1:0]);
  end

  always @(posedge clk) begin
    pipe3[0] <= (mem_en3 && mem_we3 == 2'b00) ? mem3[mem_addr3[9:2]] : 32'hBAD0_0003;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    if (mem_en3 && mem_we3 != 2'b00)
      mem3[mem_addr3[9:2]] = merge(mem3[mem_addr3[9:2]], mem_wd3, mem_we3, mem_addr3[1:0]);
  end

  assign mem_rd1 = pipe1;
  assign mem_rd3 = pipe3[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        is_i;
    logic [1:0]  we;
    logic [31:0] addr;
    logic [31:0] wd;
    int unsigned ack_cyc;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  // One transaction on the MEM_LAT=1 instance, starting in an IDLE cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int unsigned got = 0;
    int unsigned en_cnt = 0;
    logic [31:0] rd = '0;
    logic [1:0]  we_c1 = 2'b00;
    logic [31:0] a_c1 = '0;
    logic [31:0] wd_c1 = '0;
    logic        en_c1 = 1'b0;
    logic        wrong = 1'b0;
    if (v.is_i) begin
      i_req1 = 1'b1; i_addr1 = v.addr;
    end else begin
      d_req1 = 1'b1; d_addr1 = v.addr; d_we1 = v.we; d_wd1 = v.wd;
    end
    for (int c = 1; c <= 12 && got == 0; c++) begin
      @(negedge clk);
      if (mem_en1) en_cnt++;
      if (c == 1) begin
        en_c1 = mem_en1; we_c1 = mem_we1; a_c1 = mem_addr1; wd_c1 = mem_wd1;
      end
      if (d_ack1 || i_ack1) begin
        got = c; rd = rdata1;
        wrong = v.is_i ? d_ack1 : i_ack1;
        d_req1 = 1'b0; i_req1 = 1'b0;
      end
    end
    d_req1 = 1'b0; i_req1 = 1'b0;
    chk($sformatf("v%0d_ack_cycle", idx), got, v.ack_cyc);
    chk($sformatf("v%0d_ack_port", idx), {31'd0, wrong}, 32'd0);
    chk($sformatf("v%0d_rdata", idx), rd, v.exp_rd);
    chk($sformatf("v%0d_en_cycle1", idx), {31'd0, en_c1}, 32'd1);
    chk($sformatf("v%0d_en_count", idx), en_cnt, 32'd1);
    chk($sformatf("v%0d_issue_we", idx), {30'd0, we_c1}, {30'd0, v.we});
    chk($sformatf("v%0d_issue_addr", idx), a_c1, v.addr);
    if (v.we != 2'b00) chk($sformatf("v%0d_issue_wd", idx), wd_c1, v.wd);
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", idx), {31'd0, busy1}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] ack_mask;
    logic [4:0]  ack_seq;
    int unsigned n_ack;
    logic [15:0] en_mask;
    int unsigned d_cyc, i_cyc;
    logic [31:0] d_rd, i_rd, a_c1, a_c4, a_c7;
    logic        busy_c6, bad;

    for (int i = 0; i < 256; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end
    mem1[16] = 32'h0050_0093;
    mem1[65] = 32'hCAFE_F00D;
    mem3[16] = 32'h1111_2222;
    mem3[32] = 32'h3333_4444;

    vecs[0] = '{1'b0, 2'b11, 32'h100, 32'hDEAD_BEEF, 2, 32'h0000_0000};
    vecs[1] = '{1'b0, 2'b00, 32'h100, 32'h0,         3, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 2'b00, 32'h040, 32'h0,         3, 32'h0050_0093};
    vecs[3] = '{1'b0, 2'b01, 32'h101, 32'h0000_A500, 2, 32'h0050_0093};
    vecs[4] = '{1'b0, 2'b10, 32'h102, 32'h1234_0000, 2, 32'h0050_0093};
    vecs[5] = '{1'b0, 2'b00, 32'h100, 32'h0,         3, 32'h1234_A5EF};
    vecs[6] = '{1'b1, 2'b00, 32'h104, 32'h0,         3, 32'hCAFE_F00D};

    repeat (2) @(negedge clk);
    chk("rst_ctrl1", {26'd0, d_ack1, i_ack1, busy1, mem_en1, mem_we1}, 32'd0);
    chk("rst_addr1", mem_addr1, 32'd0);
    chk("rst_wd1", mem_wd1, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_ctrl3", {26'd0, d_ack3, i_ack3, busy3, mem_en3, mem_we3}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

    // Both ports requesting continuously on the MEM_LAT=1 instance.
    ack_mask = '0; ack_seq = '0; n_ack = 0;
    d_req1 = 1'b1; d_we1 = 2'b00; d_addr1 = 32'h100;
    i_req1 = 1'b1; i_addr1 = 32'h040;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (d_ack1 || i_ack1) begin
        ack_mask[c] = 1'b1;
        if (n_ack < 5) ack_seq[n_ack] = i_ack1;
        chk($sformatf("tie_rdata_%0d", n_ack), rdata1,
            i_ack1 ? 32'h0050_0093 : 32'h1234_A5EF);
        n_ack++;
      end
      if (c == 19) begin
        d_req1 = 1'b0; i_req1 = 1'b0;
      end
    end
    @(negedge clk);
    chk("tie_ack_cycles", {12'd0, ack_mask}, 32'h0008_8888);
    chk("tie_ack_count", n_ack, 32'd5);
`ifdef ARB_ROUND_ROBIN_EN
    chk("tie_ack_order", {27'd0, ack_seq}, 32'b01010);
`else
    chk("tie_ack_order", {27'd0, ack_seq}, 32'b00000);
`endif

    // MEM_LAT=3: data read, instruction request raised during WAIT.
    en_mask = '0; d_cyc = 0; i_cyc = 0; d_rd = '0; i_rd = '0;
    a_c1 = '0; a_c4 = '0; a_c7 = '0; busy_c6 = 1'b1;
    d_req3 = 1'b1; d_we3 = 2'b00; d_addr3 = 32'h040;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (mem_en3) en_mask[c] = 1'b1;
      if (c == 1) a_c1 = mem_addr3;
      if (c == 4) a_c4 = mem_addr3;
      if (c == 6) busy_c6 = busy3;
      if (c == 7) a_c7 = mem_addr3;
      if (d_ack3 && d_cyc == 0) begin
        d_cyc = c; d_rd = rdata3; d_req3 = 1'b0;
      end
      if (i_ack3 && i_cyc == 0) begin
        i_cyc = c; i_rd = rdata3; i_req3 = 1'b0;
      end
      if (c == 2) begin
        i_req3 = 1'b1; i_addr3 = 32'h080;
      end
    end
    d_req3 = 1'b0; i_req3 = 1'b0;
    chk("lat3_d_ack_cycle", d_cyc, 32'd5);
    chk("lat3_d_rdata", d_rd, 32'h1111_2222);
    chk("lat3_i_ack_cycle", i_cyc, 32'd11);
    chk("lat3_i_rdata", i_rd, 32'h3333_4444);
    chk("lat3_en_cycles", {16'd0, en_mask}, 32'h0000_0082);
    chk("lat3_addr_c1", a_c1, 32'h040);
    chk("lat3_addr_hold_c4", a_c4, 32'h040);
    chk("lat3_idle_busy_c6", {31'd0, busy_c6}, 32'd0);
    chk("lat3_addr_c7", a_c7, 32'h080);

    // Reset asserted while the MEM_LAT=3 instance is in WAIT.
    d_req3 = 1'b1; d_we3 = 2'b00; d_addr3 = 32'h040;
    repeat (2) @(negedge clk);
    chk("rstw_busy_before", {31'd0, busy3}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_ctrl", {26'd0, d_ack3, i_ack3, busy3, mem_en3, mem_we3}, 32'd0);
    chk("rstw_addr", mem_addr3, 32'd0);
    chk("rstw_rdata", rdata3, 32'd0);
    d_req3 = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bad = bad | d_ack3 | i_ack3 | busy3;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      bad = bad | d_ack3 | i_ack3 | busy3;
    end
    chk("rstw_no_ack_idle", {31'd0, bad}, 32'd0);
    chk("rstw_rdata_after", rdata3, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
